// File: rtl/ir_fetch.sv
// Instruction fetch stage: owns the program counter, issues single-word reads to
// program memory and holds the fetched word in the instruction register.
module ir_fetch #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int OPCODE_WIDTH = 7,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = {ADDR_WIDTH{1'b0}}
) (
  input  logic                             clock,
  input  logic                             notReset,
  input  logic                             fetch,
  input  logic                             load_pc,
  input  logic [ADDR_WIDTH-1:0]            pc_in,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_read,
  input  logic                             mem_ready,
  input  logic [DATA_WIDTH-1:0]            mem_data,
  output logic [OPCODE_WIDTH-1:0]          opcode,
  output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] operand,
  output logic                             valid,
  output logic [ADDR_WIDTH-1:0]            pc,
  output logic                             busy
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_pc,        w_pc_nxt;
  logic [DATA_WIDTH-1:0]   r_ir,        w_ir_nxt;
  logic                    r_valid,     w_valid_nxt;
  logic                    r_mem_read,  w_mem_read_nxt;
  logic [ADDR_WIDTH-1:0]   r_mem_addr,  w_mem_addr_nxt;
  logic                    r_pend_fetch, w_pend_fetch_nxt;
  logic                    r_pend_load,  w_pend_load_nxt;
  logic [ADDR_WIDTH-1:0]   r_target,    w_target_nxt;
  logic                    w_start;
  logic                    w_done;

  // A load in IDLE takes priority; any fetch seen with it is deferred one edge.
  assign w_start = (r_state == ST_IDLE) && !load_pc && (fetch || r_pend_fetch);
  assign w_done  = (r_state == ST_WAIT) && mem_ready;

  // State register
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values for the registered datapath and outputs
  always_comb begin
    w_pc_nxt         = r_pc;
    w_ir_nxt         = r_ir;
    w_valid_nxt      = r_valid;
    w_mem_read_nxt   = r_mem_read;
    w_mem_addr_nxt   = r_mem_addr;
    w_pend_fetch_nxt = r_pend_fetch;
    w_pend_load_nxt  = r_pend_load;
    w_target_nxt     = r_target;
    case (r_state)
      ST_IDLE: begin
        if (load_pc) begin
          w_pc_nxt         = pc_in;
          w_pend_fetch_nxt = r_pend_fetch | fetch;
        end else if (w_start) begin
          w_mem_addr_nxt   = r_pc;
          w_mem_read_nxt   = 1'b1;
          w_valid_nxt      = 1'b0;
          w_pend_fetch_nxt = 1'b0;
        end else begin
          w_pend_fetch_nxt = r_pend_fetch;
        end
      end
      ST_WAIT: begin
        if (fetch) begin
          w_pend_fetch_nxt = 1'b1;
        end else begin
          w_pend_fetch_nxt = r_pend_fetch;
        end
        if (load_pc) begin
          w_target_nxt    = pc_in;
          w_pend_load_nxt = 1'b1;
        end else begin
          w_target_nxt    = r_target;
        end
        if (w_done) begin
          w_ir_nxt        = mem_data;
          w_valid_nxt     = 1'b1;
          w_mem_read_nxt  = 1'b0;
          w_pend_load_nxt = 1'b0;
          // A jump arriving on the completion edge itself wins over a saved one.
          if (load_pc) begin
            w_pc_nxt = pc_in;
          end else if (r_pend_load) begin
            w_pc_nxt = r_target;
          end else begin
            w_pc_nxt = r_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          end
        end else begin
          w_ir_nxt = r_ir;
        end
      end
      default: begin
        w_mem_read_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      r_pc         <= RESET_PC;
      r_ir         <= {DATA_WIDTH{1'b0}};
      r_valid      <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_addr   <= {ADDR_WIDTH{1'b0}};
      r_pend_fetch <= 1'b0;
      r_pend_load  <= 1'b0;
      r_target     <= {ADDR_WIDTH{1'b0}};
    end else begin
      r_pc         <= w_pc_nxt;
      r_ir         <= w_ir_nxt;
      r_valid      <= w_valid_nxt;
      r_mem_read   <= w_mem_read_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_pend_fetch <= w_pend_fetch_nxt;
      r_pend_load  <= w_pend_load_nxt;
      r_target     <= w_target_nxt;
    end
  end

  assign mem_addr = r_mem_addr;
  assign mem_read = r_mem_read;
  assign opcode   = r_ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign operand  = r_ir[DATA_WIDTH-OPCODE_WIDTH-1:0];
  assign valid    = r_valid;
  assign pc       = r_pc;
  assign busy     = (r_state == ST_WAIT);

endmodule

// File: doc/ir_fetch.md
# ir_fetch

Instruction fetch and instruction register stage directly upstream of the microsequencer. On a fetch request from the microsequencer's control word, it reads one word from program memory at the program counter. It then latches that word into the instruction register and presents the opcode field, with the remaining operand bits, to the microsequencer. It owns the program counter: increment after each fetch, plus absolute loads for jumps.

## Interface
Parameters:
- DATA_WIDTH, 16, instruction word width
- ADDR_WIDTH, 16, program counter / memory address width
- OPCODE_WIDTH, 7, opcode field width; opcode = instruction[DATA_WIDTH-1 -: OPCODE_WIDTH]
- RESET_PC, 0, program counter value after reset

Ports:
- clock  in  1  system clock, rising edge
- notReset  in  1  asynchronous active-low reset
- fetch  in  1  fetch request from the microsequencer control word, sampled each rising edge
- load_pc  in  1  load program counter from pc_in
- pc_in  in  ADDR_WIDTH  jump target
- mem_addr  out  ADDR_WIDTH  registered memory read address
- mem_read  out  1  registered memory read request
- mem_ready  in  1  memory has valid data on mem_data; only meaningful while mem_read=1
- mem_data  in  DATA_WIDTH  memory read data
- opcode  out  OPCODE_WIDTH  opcode field of the instruction register
- operand  out  DATA_WIDTH-OPCODE_WIDTH  remaining instruction register bits
- valid  out  1  instruction register holds a completed fetch
- pc  out  ADDR_WIDTH  current program counter
- busy  out  1  fetch in progress (state WAIT)

## Operation
- Reset (notReset=0, asynchronous) sets the following; a reset mid-WAIT abandons the fetch.
  - pc=RESET_PC, instruction register=0 (opcode=0, operand=0), valid=0.
  - mem_read=0, mem_addr=0, busy=0.
  - State IDLE, pending_fetch=0, pending_load=0.
- IDLE:
  - fetch=1 and load_pc=0: mem_addr<=pc, mem_read<=1, valid<=0, go to WAIT.
  - load_pc=1: pc<=pc_in. If fetch=1 in the same cycle, set pending_fetch; the fetch then starts on the next edge from the new pc.
  - pending_fetch=1 acts exactly like fetch=1, and is cleared when the fetch starts.
- WAIT (busy=1, mem_read=1, mem_addr held stable):
  - On the edge where mem_ready=1:
    - IR<=mem_data, valid<=1, mem_read<=0.
    - pc<=pc+1 modulo 2^ADDR_WIDTH, so pc=all-ones wraps to 0.
    - If pending_load is set, pc<=the saved target instead of incrementing, and pending_load is cleared.
    - Go to IDLE.
  - load_pc=1 in WAIT: save pc_in and set pending_load. A later load in the same WAIT overwrites the saved target. The in-flight read is never aborted.
  - fetch=1 in WAIT: set pending_fetch (depth one; further requests are dropped).
  - mem_ready while mem_read=0 is ignored.
- opcode and operand change only on the completion edge and are otherwise stable. valid drops on the edge a new fetch starts.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Edge E0 samples fetch=1. From E0: mem_read=1, mem_addr=pc.
- The first possible completion is edge E1, when mem_ready=1 at E1. From E1: valid=1, new opcode, pc+1.
- Fetch-to-valid latency is 1 + N edges, where N is the number of wait edges with mem_ready=0.
- Back-to-back:
  - A pending_fetch starts on the edge after completion, giving a minimum 2-edge issue interval.
  - An IDLE fetch that arrives together with load_pc costs one extra edge.

## Test plan
- Reset: assert notReset=0 mid-WAIT with RESET_PC=0x0100.
  - Required: immediately pc=0x0100, mem_read=0, valid=0, opcode=0, busy=0.
- Single fetch: pc=0x0100, mem_ready held 1, mem_data=0xA5C3.
  - Required: mem_read=1 and mem_addr=0x0100 for exactly one cycle.
  - Then valid=1, opcode=0x52, operand=0x1C3, pc=0x0101.
- Wait states: mem_ready low for 3 edges.
  - Required: mem_addr stable, busy=1 for 4 cycles, valid=0 throughout, then completion as above.
- Jump during WAIT: load_pc=1 with pc_in=0x2000 mid-WAIT.
  - Required: fetched word is still latched, pc=0x2000 (not pc+1). The next fetch reads address 0x2000.
- Wrap and queued fetch: pc=0xFFFF, fetch re-asserted during WAIT.
  - Required: pc becomes 0x0000 after completion. The second read starts the next edge with mem_addr=0x0000.
- Simultaneous load and fetch in IDLE: load_pc=1, pc_in=0x0040, fetch=1.
  - Required: no read that cycle. The read issues one edge later with mem_addr=0x0040.
